alu_wide_seq: RTL and testbench
===============================

# alu_wide_seq

Multi-cycle sequencer that executes 16-bit operations on the 8-bit combinational `alu`, sitting directly upstream of it. It latches wide operands on `start` and drives the ALU low byte then high byte, or high then low for `lsr`. It chains carry between halves, merges the byte results, and reports 16-bit result plus processor flags with a `done` pulse.

## Interface
Parameters:
- None. Byte width, flag width, flag indices and oper encodings come from the shared ALU/flags defines.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `oper`  in  ALU oper width  wide operation: `add`, `adc`, `sub`, `sbc`, `cmp`, `and`, `orr`, `xor`, `lsr` encodings.
- `a_in`, `b_in`  in  16 each  wide operands.
- `proc_flags_in`  in  flags width  incoming flags.
- `busy`  out  1  high in LO/HI states.
- `done`  out  1  one-cycle completion pulse.
- `out`  out  16  wide result, held until next completion.
- `proc_flags_out`  out  flags width  result flags, held like `out`.
- `alu_oper`  out  ALU oper width  to `alu`.
- `alu_a`, `alu_b`  out  8 each  to `alu`.
- `alu_flags_in`  out  flags width  to `alu`.
- `alu_out`  in  8  from `alu`.
- `alu_flags_out`  in  flags width  from `alu`.

## Operation
- On accepted `start`: latch `oper`, `a_in`, `b_in`, `proc_flags_in`.
- States: IDLE → FIRST → SECOND → DONE → IDLE, or DONE → FIRST on a new `start`.
- Byte order is low then high, except `lsr`, which is high then low.
- `add`/`adc`: FIRST issues `add`/`adc` on the low bytes, with the latched C for `adc`. SECOND issues `adc` on the high bytes, with C from FIRST.
- `sub`/`sbc`: same pattern using `sub`/`sbc`, then `sbc`. C means "no borrow".
- `cmp`: executed as `sub` then `sbc`. `out` is not updated; only flags change.
- `and`/`orr`/`xor`: the same op on each byte. C equals the latched C.
- `lsr`: FIRST issues `lsr` on the high byte and captures carry c1. SECOND issues `lsr` on the low byte and captures c2. Low result byte = {c1, alu_out[6:0]}; final C = c2.
- Z = (merged 16-bit result == 0). It is computed by the sequencer, never taken from the ALU Z. For `cmp`, Z is computed on the discarded difference.
- All flag bits other than C and Z pass through from the latched flags.
- Unsupported `oper` value: runs both cycles with no ALU side effect. On `done`, `out` is unchanged and `proc_flags_out` = latched flags.
- `alu_flags_in` = latched flags with C replaced by the chained carry in SECOND.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `out`=0, `proc_flags_out`=0, `alu_a`=`alu_b`=0, `alu_oper`=`add` encoding, `alu_flags_in`=0.
- `start` sampled at edge N: FIRST during N+1, SECOND during N+2. `done`=1 and `out`/flags valid during N+3. Latency is 3 cycles.
- ALU inputs are driven from registers during FIRST/SECOND. `alu_out`/`alu_flags_out` are captured at the end of that same cycle.
- `start` while `busy` is ignored, and the latched operands are not disturbed.
- `start` during DONE is accepted: back-to-back throughput is one op per 3 cycles.
- `rst` has priority over everything. Reset mid-operation aborts the op: no `done` pulse, and outputs return to reset values.

## Structure
- The shared ALU defines package holds the oper encodings and the byte/wide width constants.
- The shared flags package holds the flags width and C/Z indices.
- The sequencer state encoding is local to this block.
- No sub-module. `alu` is instantiated beside this block by the parent, not inside it. The bench instantiates both.

## Test plan
- `add` 0x12FF + 0x0001, C_in=0 → `out`=0x1300, C=0, Z=0, `done` at N+3.
- `sub` 0x1000 − 0x0001 → `out`=0x0FFF, C=1. `sub` 0x0000 − 0x0001 → 0xFFFF, C=0.
- `cmp` 0x1234 vs 0x1234 with prior `out`=0x5555 → Z=1, C=1, `out` stays 0x5555.
- `lsr` 0x0101 → `out`=0x0080, C=1, Z=0. `xor` 0xAAAA ^ 0xAAAA with C_in=1 → 0x0000, Z=1, C=1.
- `start` pulsed in FIRST with different operands → ignored, and the original result is reported. Back-to-back `start` in DONE → second `done` 3 cycles later.
- `rst` asserted during SECOND → no `done`. Next cycle, all outputs are at reset values; the next op completes normally.

Source files
------------

// File: rtl/alu_wide_seq_pkg.sv
// Shared ALU and processor-flag definitions: byte/wide widths, oper encodings,
// flag indices and the wide-to-byte oper mapping used by the sequencer.
package alu_wide_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int WIDE_W  = 16;
  localparam int OPER_W  = 4;
  localparam int FLAGS_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [OPER_W-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_CMP = 4'd4,
    OP_AND = 4'd5,
    OP_ORR = 4'd6,
    OP_XOR = 4'd7,
    OP_LSR = 4'd8
  } oper_e;

  // Byte oper issued in the first cycle of a wide op; cmp runs as a plain sub.
  function automatic logic [OPER_W-1:0] first_op(input logic [OPER_W-1:0] op);
    case (op)
      OP_CMP:  return OP_SUB;
      default: return op;
    endcase
  endfunction

  // Byte oper issued in the second cycle; arithmetic chains through the carry.
  function automatic logic [OPER_W-1:0] second_op(input logic [OPER_W-1:0] op);
    case (op)
      OP_ADD, OP_ADC:         return OP_ADC;
      OP_SUB, OP_SBC, OP_CMP: return OP_SBC;
      default:                return op;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU; lives beside the wide sequencer in the parent.
// C is "carry" for add and "no borrow" for subtract; lsr shifts bit 0 into C.
module alu
  import alu_wide_seq_pkg::*;
(
  input  logic [OPER_W-1:0]  oper,
  input  logic [BYTE_W-1:0]  a,
  input  logic [BYTE_W-1:0]  b,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [BYTE_W-1:0]  out,
  output logic [FLAGS_W-1:0] flags_out
);

  logic [BYTE_W:0] sum;
  logic            c_in;
  logic            c_res;
  logic [BYTE_W-1:0] zn_src;
  logic            known;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    c_in   = flags_in[FLAG_C];
    sum    = '0;
    out    = '0;
    c_res  = c_in;
    known  = 1'b1;
    case (oper)
      OP_ADD: sum = {1'b0, a} + {1'b0, b};
      OP_ADC: sum = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c_in};
      OP_SUB, OP_CMP: sum = {1'b0, a} + {1'b0, ~b} + {{BYTE_W{1'b0}}, 1'b1};
      OP_SBC: sum = {1'b0, a} + {1'b0, ~b} + {{BYTE_W{1'b0}}, c_in};
      default: sum = '0;
    endcase
    case (oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        out   = sum[BYTE_W-1:0];
        c_res = sum[BYTE_W];
      end
      OP_CMP: begin
        out   = a;
        c_res = sum[BYTE_W];
      end
      OP_AND: out = a & b;
      OP_ORR: out = a | b;
      OP_XOR: out = a ^ b;
      OP_LSR: begin
        out   = {1'b0, a[BYTE_W-1:1]};
        c_res = a[0];
      end
      default: known = 1'b0;
    endcase
    zn_src = (oper == OP_CMP) ? sum[BYTE_W-1:0] : out;

    flags_out = flags_in;
    if (known) begin
      flags_out[FLAG_C] = c_res;
      flags_out[FLAG_Z] = (zn_src == '0);
      flags_out[FLAG_N] = zn_src[BYTE_W-1];
    end
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Sequencer running 16-bit ops as two passes through the external 8-bit alu,
// chaining carry between halves and merging the byte results and flags.
module alu_wide_seq
  import alu_wide_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OPER_W-1:0]  oper,
  input  logic [WIDE_W-1:0]  a_in,
  input  logic [WIDE_W-1:0]  b_in,
  input  logic [FLAGS_W-1:0] proc_flags_in,
  output logic               busy,
  output logic               done,
  output logic [WIDE_W-1:0]  out,
  output logic [FLAGS_W-1:0] proc_flags_out,
  output logic [OPER_W-1:0]  alu_oper,
  output logic [BYTE_W-1:0]  alu_a,
  output logic [BYTE_W-1:0]  alu_b,
  output logic [FLAGS_W-1:0] alu_flags_in,
  input  logic [BYTE_W-1:0]  alu_out,
  input  logic [FLAGS_W-1:0] alu_flags_out
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} state_e;

  state_e             state;
  logic [OPER_W-1:0]  lat_oper;
  logic [WIDE_W-1:0]  lat_a;
  logic [WIDE_W-1:0]  lat_b;
  logic [FLAGS_W-1:0] lat_flags;
  logic [BYTE_W-1:0]  first_out;
  logic               first_c;

  logic               in_lsr;
  logic [WIDE_W-1:0]  merged;
  logic [WIDE_W-1:0]  final_out;
  logic [FLAGS_W-1:0] final_flags;
  logic [FLAGS_W-1:0] second_flags;
  logic               unused_alu_flags;

  // Only C is consumed from the alu; Z and the rest are owned by this block.
  assign unused_alu_flags = ^alu_flags_out;
  assign in_lsr = (lat_oper == OP_LSR);

  // Merge is evaluated during SECOND, when alu_out holds the second byte.
  always_comb begin
    merged       = in_lsr ? {first_out, first_c, alu_out[BYTE_W-2:0]}
                          : {alu_out, first_out};
    final_out    = merged;
    final_flags  = lat_flags;
    final_flags[FLAG_Z] = (merged == '0);
    second_flags = lat_flags;
    second_flags[FLAG_C] = alu_flags_out[FLAG_C];
    case (lat_oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_LSR:
        final_flags[FLAG_C] = alu_flags_out[FLAG_C];
      OP_CMP: begin
        final_out           = out;
        final_flags[FLAG_C] = alu_flags_out[FLAG_C];
      end
      OP_AND, OP_ORR, OP_XOR: final_flags[FLAG_C] = lat_flags[FLAG_C];
      default: begin
        final_out   = out;
        final_flags = lat_flags;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      out            <= '0;
      proc_flags_out <= '0;
      alu_oper       <= OP_ADD;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_flags_in   <= '0;
      lat_oper       <= OP_ADD;
      lat_a          <= '0;
      lat_b          <= '0;
      lat_flags      <= '0;
      first_out      <= '0;
      first_c        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lat_oper     <= oper;
            lat_a        <= a_in;
            lat_b        <= b_in;
            lat_flags    <= proc_flags_in;
            alu_oper     <= first_op(oper);
            alu_a        <= (oper == OP_LSR) ? a_in[WIDE_W-1:BYTE_W] : a_in[BYTE_W-1:0];
            alu_b        <= (oper == OP_LSR) ? b_in[WIDE_W-1:BYTE_W] : b_in[BYTE_W-1:0];
            alu_flags_in <= proc_flags_in;
            busy         <= 1'b1;
            state        <= S_FIRST;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FIRST: begin
          first_out    <= alu_out;
          first_c      <= alu_flags_out[FLAG_C];
          alu_oper     <= second_op(lat_oper);
          alu_a        <= in_lsr ? lat_a[BYTE_W-1:0] : lat_a[WIDE_W-1:BYTE_W];
          alu_b        <= in_lsr ? lat_b[BYTE_W-1:0] : lat_b[WIDE_W-1:BYTE_W];
          alu_flags_in <= second_flags;
          state        <= S_SECOND;
        end
        S_SECOND: begin
          out            <= final_out;
          proc_flags_out <= final_flags;
          done           <= 1'b1;
          busy           <= 1'b0;
          state          <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Scoreboard bench for alu_wide_seq wired to the 8-bit alu; expected results
// come from a 16-bit arithmetic model and are popped on each done pulse.
module tb_alu_wide_seq;
  import alu_wide_seq_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic [OPER_W-1:0]  oper;
  logic [WIDE_W-1:0]  a_in;
  logic [WIDE_W-1:0]  b_in;
  logic [FLAGS_W-1:0] proc_flags_in;
  logic               busy;
  logic               done;
  logic [WIDE_W-1:0]  out;
  logic [FLAGS_W-1:0] proc_flags_out;
  logic [OPER_W-1:0]  alu_oper;
  logic [BYTE_W-1:0]  alu_a;
  logic [BYTE_W-1:0]  alu_b;
  logic [FLAGS_W-1:0] alu_flags_in;
  logic [BYTE_W-1:0]  alu_out;
  logic [FLAGS_W-1:0] alu_flags_out;

  typedef struct {
    logic [WIDE_W-1:0]  out;
    logic [FLAGS_W-1:0] flags;
  } exp_t;

  exp_t              sb[$];
  logic [WIDE_W-1:0] model_out;
  int                n_checks = 0;
  int                n_errors = 0;

  alu_wide_seq dut (
    .clk(clk), .rst(rst), .start(start), .oper(oper), .a_in(a_in), .b_in(b_in),
    .proc_flags_in(proc_flags_in), .busy(busy), .done(done), .out(out),
    .proc_flags_out(proc_flags_out), .alu_oper(alu_oper), .alu_a(alu_a),
    .alu_b(alu_b), .alu_flags_in(alu_flags_in), .alu_out(alu_out),
    .alu_flags_out(alu_flags_out)
  );

  alu u_alu (
    .oper(alu_oper), .a(alu_a), .b(alu_b), .flags_in(alu_flags_in),
    .out(alu_out), .flags_out(alu_flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [OPER_W-1:0] op, input logic [WIDE_W-1:0] a,
                                 input logic [WIDE_W-1:0] b, input logic [FLAGS_W-1:0] f,
                                 input logic [WIDE_W-1:0] prev);
    exp_t        e;
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = f[FLAG_C];
    r = prev;
    case (op)
      OP_ADD: s = {1'b0, a} + {1'b0, b};
      OP_ADC: s = {1'b0, a} + {1'b0, b} + {16'd0, c};
      OP_SUB, OP_CMP: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      OP_SBC: s = {1'b0, a} + {1'b0, ~b} + {16'd0, c};
      default: s = '0;
    endcase
    e.out   = prev;
    e.flags = f;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin r = s[15:0]; c = s[16]; e.out = r; end
      OP_CMP: begin r = s[15:0]; c = s[16]; end
      OP_AND: begin r = a & b; e.out = r; end
      OP_ORR: begin r = a | b; e.out = r; end
      OP_XOR: begin r = a ^ b; e.out = r; end
      OP_LSR: begin r = a >> 1; c = a[0]; e.out = r; end
      default: return e;
    endcase
    e.flags[FLAG_C] = c;
    e.flags[FLAG_Z] = (r == 16'd0);
    return e;
  endfunction

  // Caller is at a negedge; start is presented for exactly one edge.
  task automatic issue(input logic [OPER_W-1:0] op, input logic [WIDE_W-1:0] a,
                       input logic [WIDE_W-1:0] b, input logic [FLAGS_W-1:0] f);
    exp_t e;
    oper = op; a_in = a; b_in = b; proc_flags_in = f; start = 1'b1;
    e = model(op, a, b, f, model_out);
    model_out = e.out;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_n);
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(exp_n));
  endtask

  task automatic run(input logic [OPER_W-1:0] op, input logic [WIDE_W-1:0] a,
                     input logic [WIDE_W-1:0] b, input logic [FLAGS_W-1:0] f);
    issue(op, a, b, f);
    wait_done(2);
  endtask

  task automatic check_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'(proc_flags_out), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_oper", 32'(alu_oper), 32'(OP_ADD));
    check("rst_alu_flags", 32'(alu_flags_in), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out", 32'(out), 32'(e.out));
        check("flags", 32'(proc_flags_out), 32'(e.flags));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; oper = '0; a_in = '0; b_in = '0; proc_flags_in = '0;
    model_out = '0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    run(OP_ADD, 16'h12FF, 16'h0001, 4'b0100);
    run(OP_SUB, 16'h1000, 16'h0001, 4'b1000);
    run(OP_SUB, 16'h0000, 16'h0001, 4'b0001);
    run(OP_ORR, 16'h5555, 16'h0000, 4'b0000);
    run(OP_CMP, 16'h1234, 16'h1234, 4'b1100);
    check("cmp_holds_out", 32'(out), 32'h5555);
    run(OP_LSR, 16'h0101, 16'h0000, 4'b0000);
    run(OP_XOR, 16'hAAAA, 16'hAAAA, 4'b0001);
    run(OP_ADC, 16'h00FF, 16'h0F00, 4'b0001);
    run(OP_SBC, 16'h0100, 16'h0001, 4'b0000);
    run(OP_AND, 16'hF0F0, 16'h3C3C, 4'b1001);
    run(4'hC, 16'hFFFF, 16'hFFFF, 4'b1010);

    // start during FIRST with other operands must be ignored
    issue(OP_ADD, 16'h0100, 16'h0200, 4'b0000);
    oper = OP_SUB; a_in = 16'hFFFF; b_in = 16'h1111; proc_flags_in = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);

    // back-to-back starts presented in the DONE cycle
    issue(OP_ADD, 16'hFFFF, 16'h0001, 4'b0000);
    wait_done(2);
    for (int i = 0; i < 12; i++) begin
      issue(4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 4'($urandom));
      wait_done(2);
    end
    @(negedge clk);

    // reset during SECOND aborts the op
    issue(OP_ADD, 16'h1111, 16'h2222, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_out = '0;
    check_reset();
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run(OP_ADD, 16'h0F0F, 16'h0101, 4'b0000);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
